// File: rtl/sync_fifo_pkg.sv
// Shared sizing defaults for the single-clock FWFT FIFO.
// Combinational only, with no handshake of its own.
package sync_fifo_pkg;

    localparam int unsigned DSIZE_DEF = 8;
    localparam int unsigned ASIZE_DEF = 3;

    function automatic int unsigned depth_of(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE register array with a synchronous write port and an asynchronous read port.
// Writes land on the next clk edge. Reads are combinational. There is no flow control here.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int unsigned DEPTH = depth_of(ASIZE);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [DSIZE-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wen) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage is deliberately left out of reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO: the head word sits on rdata while not empty, and write-to-read latency is 1 clk.
// A write while full or a read while empty is dropped silently, and full/empty come from registered pointers.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           wr_acc;
    logic           rd_acc;

    // The extra MSB is a wrap bit that tells full apart from empty when the addresses match.
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                    (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    assign wr_acc = winc && !full;
    assign rd_acc = rinc && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    sync_fifo_mem #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_mem (
        .clk  (clk),
        .wen  (wr_acc),
        .waddr(wptr_q[ASIZE-1:0]),
        .wdata(wdata),
        .raddr(rptr_q[ASIZE-1:0]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo. A queue model is compared on every falling edge, and directed literals pin the model.
module tb_sync_fifo;

    localparam int DEPTH = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic       winc  = 1'b0;
    logic       rinc  = 1'b0;
    logic [7:0] rdata;
    logic       full;
    logic       empty;

    int checks = 0;
    int passes = 0;

    logic [7:0] model_q[$];

    sync_fifo #(.DSIZE(8), .ASIZE(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wdata(wdata),
        .winc (winc),
        .rinc (rinc),
        .rdata(rdata),
        .full (full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference: the occupancy decides acceptance before the edge, then pop and push happen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            automatic bit w = winc && (model_q.size() < DEPTH);
            automatic bit r = rinc && (model_q.size() > 0);
            if (r) void'(model_q.pop_front());
            if (w) model_q.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        chk("model_empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
        chk("model_full", {31'd0, full}, {31'd0, model_q.size() == DEPTH});
        if (model_q.size() > 0) chk("model_rdata", {24'd0, rdata}, {24'd0, model_q[0]});
    end

    // Inputs are applied between edges, the edge happens, and then the inputs return to idle at edge+1.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge clk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill in order, then drain in order.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        chk("basic_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("basic_data", {24'd0, rdata}, 32'h11 * (i + 1));
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("basic_empty", {31'd0, empty}, 32'd1);

        // Writes past full are dropped.
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, 8'(8'hA0 + i), 1'b0);
            if (i == 6) chk("ovf_not_full7", {31'd0, full}, 32'd0);
        end
        chk("ovf_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_data", {24'd0, rdata}, 32'hA0 + i);
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("ovf_empty", {31'd0, empty}, 32'd1);

        // Reads while empty are ignored.
        repeat (11) cyc(1'b0, 8'h00, 1'b1);
        chk("udf_empty", {31'd0, empty}, 32'd1);
        cyc(1'b1, 8'h5C, 1'b0);
        chk("udf_not_empty", {31'd0, empty}, 32'd0);
        chk("udf_data", {24'd0, rdata}, 32'h5C);
        cyc(1'b0, 8'h00, 1'b1);

        // Simultaneous push and pop with 4 words stored, across the pointer wrap.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("sim_data", {24'd0, rdata}, 32'hB0 + i);
            cyc(1'b1, 8'(8'hB4 + i), 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            chk("sim_drain", {24'd0, rdata}, 32'hBA + i);
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("sim_empty", {31'd0, empty}, 32'd1);

        // When full, a combined request performs only the read.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        cyc(1'b1, 8'hCF, 1'b1);
        chk("fullrw_full", {31'd0, full}, 32'd0);
        for (int i = 1; i < 8; i++) begin
            chk("fullrw_data", {24'd0, rdata}, 32'hC0 + i);
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("fullrw_empty", {31'd0, empty}, 32'd1);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_empty", {31'd0, empty}, 32'd1);
        chk("mrst_full", {31'd0, full}, 32'd0);
        #1 rst_n = 1'b1;
        cyc(1'b1, 8'h77, 1'b0);
        chk("mrst_not_empty", {31'd0, empty}, 32'd0);
        chk("mrst_data", {24'd0, rdata}, 32'h77);
        cyc(1'b0, 8'h00, 1'b1);
        chk("mrst_drained", {31'd0, empty}, 32'd1);

        // Random traffic checked by the model, with writes biased early and reads biased late.
        for (int i = 0; i < 100; i++) begin
            automatic int wp = (i < 50) ? 70 : 35;
            automatic int rp = (i < 50) ? 35 : 70;
            cyc(1'($urandom_range(99) < wp), 8'($urandom), 1'($urandom_range(99) < rp));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
